ysyx_24110015_fetch_queue: RTL and testbench
============================================

YSYX_24110015_FETCH_QUEUE -- requirements
Module: ysyx_24110015_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, width of pc and inst fields.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert and active-low (0 = reset).
REQ-005 SHALL have port in_valid  input  1  IFU presents a fetched instruction.
REQ-006 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-007 SHALL have port in_pc  input  XLEN  pc of the fetched instruction.
REQ-008 SHALL have port in_inst  input  XLEN  fetched instruction word.
REQ-009 SHALL have port out_valid  output  1  head entry available to IDU.
REQ-010 SHALL have port out_ready  input  1  IDU consumes the head entry.
REQ-011 SHALL have port out_pc  output  XLEN  pc of the head entry.
REQ-012 SHALL have port out_inst  output  XLEN  instruction of the head entry.
REQ-013 SHALL have port flush  input  1  redirect from EXU/trap; discard all queued entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL buffer IFU output as an in-order FIFO of {pc, inst} pairs between IFU and IDU.
REQ-016 SHALL enqueue when in_valid && in_ready && !flush at a rising edge.
REQ-017 SHALL dequeue when out_valid && out_ready && !flush at a rising edge.
REQ-018 SHALL drive in_ready = (count != DEPTH); no dependence on out_ready (no full-bypass).
REQ-019 SHALL drive out_valid = (count != 0); no empty-bypass, so minimum in-to-out latency is 1 cycle.
REQ-020 SHALL drive out_pc/out_inst from the head entry when out_valid=1, and all-zero when out_valid=0.
REQ-021 SHALL, on simultaneous enqueue and dequeue, keep count unchanged and advance both pointers.
REQ-022 SHALL, when full, accept a push only on a later cycle after a pop has freed an entry (pop+push same cycle when full: pop only).
REQ-023 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-024 SHALL give flush priority over push and pop: next cycle count=0, pointers=0, out_valid=0, the same-cycle push dropped.
REQ-025 SHALL keep head entry and out_pc/out_inst stable while out_valid=1 and out_ready=0.
REQ-026 SHALL ignore in_pc/in_inst when no enqueue occurs.

Reset
REQ-027 SHALL, while rst=0, force count=0, read/write pointers=0, out_valid=0, in_ready=1, out_pc=0, out_inst=0, independent of clk.
REQ-028 SHALL need no reset on the storage array; emptied state masks its contents.
REQ-029 SHALL, on rst asserted mid-operation, drop all entries; first enqueue accepted on the first rising edge after rst=1.

Structure
REQ-030 SHALL take XLEN and the NOP encoding (32'h00000013) from the shared core package, which the IDU also uses.
REQ-031 SHALL be a single module with no sub-modules; storage is a register array indexed by the pointers.
REQ-032 SHALL keep count as a register, not derived from pointer difference.

Verification
REQ-033 Reset then push pc=0x80000000 inst=0x00000413 with out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, count=1.
REQ-034 Push 4 entries pc=0x80000000..0x8000000C, out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; then drain in order 0x80000000..0x8000000C.
REQ-035 Full queue, in_valid=1 and out_ready=1 same cycle -> only pop, count 4->3; push accepted next cycle, count=4.
REQ-036 Count=2, continuous push+pop for 10 cycles -> count stays 2, pointers wrap, out_pc sequence strictly ascending by 4.
REQ-037 Count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_pc=0, pushed entry absent.
REQ-038 Count=2, rst pulsed low between clock edges -> out_valid=0 and count=0 immediately; after release, push/pop resumes normally.

Source files
------------

// File: rtl/ysyx_24110015_fetch_queue_pkg.sv
// Core-wide constants shared by the fetch queue and the IDU.
package ysyx_24110015_fetch_queue_pkg;

  localparam int unsigned CORE_XLEN = 32;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24110015_fetch_queue.sv
// In-order {pc, inst} FIFO between IFU and IDU. Flush and reset discard all entries.
// The output is registered only, with no bypass, so an entry appears one cycle after enqueue at the earliest.
module ysyx_24110015_fetch_queue
  import ysyx_24110015_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = CORE_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid  && in_ready  && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (out_valid) begin
      out_pc   = r_pc_mem[r_rd_ptr];
      out_inst = r_inst_mem[r_rd_ptr];
    end
  end

  // Storage is intentionally unreset: an empty queue masks stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_fetch_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_ysyx_24110015_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            flush;
  logic [2:0]      count;

  ysyx_24110015_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_inst (out_inst),
    .flush    (flush),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"},     64'(count),     64'(q.size()));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(q.size() != DEPTH));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, "_out_pc"},    64'(out_pc),    64'((q.size() != 0) ? q[0].pc : 32'h0));
    chk({tag, "_out_inst"},  64'(out_inst),  64'((q.size() != 0) ? q[0].inst : 32'h0));
  endtask

  // Drives one cycle's inputs mid-cycle, checks outputs, then clocks the DUT and the model.
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input bit ordy, input bit fl, input string tag);
    bit   push, pop;
    ent_t e;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_model(tag);
    push = v && (q.size() < DEPTH) && !fl;
    pop  = ordy && (q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc = pc; e.inst = inst;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = '0; in_inst = '0; out_ready = 0; flush = 0;
  endtask

  // Asserts reset between clock edges and checks the outputs respond without a clock.
  task automatic pulse_reset(input string tag);
    idle_inputs();
    rst = 1'b0;
    q.delete();
    #1;
    chk({tag, "_count"},     64'(count),     64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_pc"},    64'(out_pc),    64'd0);
    chk({tag, "_out_inst"},  64'(out_inst),  64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  logic [31:0] prev_pc;

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    chk("por_count",     64'(count),     64'd0);
    chk("por_out_valid", 64'(out_valid), 64'd0);
    chk("por_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Single push: visible on the following cycle.
    cycle(1, 32'h8000_0000, 32'h0000_0413, 0, 0, "r33");
    chk("r33_valid", 64'(out_valid), 64'd1);
    chk("r33_pc",    64'(out_pc),    64'h8000_0000);
    chk("r33_cnt",   64'(count),     64'd1);
    cycle(0, '0, '0, 1, 0, "r33d");

    // Fill to full, fifth push ignored, drain in order.
    for (int i = 0; i < 5; i++)
      cycle(1, 32'h8000_0000 + 32'(4 * i), 32'h1000 + 32'(i), 0, 0, "r34f");
    chk("r34_cnt",   64'(count),    64'd4);
    chk("r34_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("r34_order", 64'(out_pc), 64'(32'h8000_0000 + 32'(4 * i)));
      cycle(0, '0, '0, 1, 0, "r34d");
    end
    chk("r34_empty", 64'(out_valid), 64'd0);

    // Full with push and pop together: pop only, push taken next cycle.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h9000_0000 + 32'(4 * i), 32'h2000 + 32'(i), 0, 0, "r35f");
    cycle(1, 32'h9000_0010, 32'h2004, 1, 0, "r35pp");
    chk("r35_cnt3", 64'(count), 64'd3);
    cycle(1, 32'h9000_0010, 32'h2004, 0, 0, "r35p");
    chk("r35_cnt4", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0, "r35d");

    // Steady state at count 2 with pointers wrapping.
    cycle(1, 32'hA000_0000, 32'h3000, 0, 0, "r36f");
    cycle(1, 32'hA000_0004, 32'h3001, 0, 0, "r36f");
    prev_pc = 32'hA000_0000 - 32'd4;
    for (int i = 0; i < 10; i++) begin
      chk("r36_cnt",  64'(count),  64'd2);
      chk("r36_step", 64'(out_pc), 64'(prev_pc + 32'd4));
      prev_pc = out_pc;
      cycle(1, 32'hA000_0008 + 32'(4 * i), 32'h3002 + 32'(i), 1, 0, "r36");
    end
    chk("r36_cnt_end", 64'(count), 64'd2);

    // Flush beats a simultaneous push and pop.
    cycle(1, 32'hB000_0000, 32'h4000, 0, 0, "r37f");
    chk("r37_cnt3", 64'(count), 64'd3);
    cycle(1, 32'hB000_0004, 32'h4001, 1, 1, "r37fl");
    chk("r37_cnt",   64'(count),     64'd0);
    chk("r37_valid", 64'(out_valid), 64'd0);
    chk("r37_pc",    64'(out_pc),    64'd0);
    cycle(1, 32'hB000_0008, 32'h4002, 0, 0, "r37a");
    chk("r37_after", 64'(out_pc), 64'hB000_0008);

    // Asynchronous reset mid-operation, then normal traffic resumes.
    cycle(1, 32'hC000_0000, 32'h5000, 0, 0, "r38f");
    chk("r38_cnt2", 64'(count), 64'd2);
    pulse_reset("r38rst");
    cycle(1, 32'hC000_0010, 32'h5001, 0, 0, "r38a");
    chk("r38_first", 64'(out_pc), 64'hC000_0010);
    cycle(1, 32'hC000_0014, 32'h5002, 1, 0, "r38b");
    cycle(0, '0, '0, 1, 0, "r38c");
    cycle(0, '0, '0, 1, 0, "r38d");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, $urandom, $urandom,
            ($urandom % 3) != 0, ($urandom % 25) == 0, "rnd");
      if (($urandom % 200) == 0) pulse_reset("rnd_rst");
    end
    check_model("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
